// File: rtl/game_state_controller.sv
// game_state_controller: per-frame collision reduction and IDLE/PLAY/WIN/LOSE game FSM
module game_state_controller #(
  parameter int N_OBJ         = 2,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 3,
  parameter int GIFT_W        = 4,
  parameter int INVULN_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              start_game,
  input  logic              drawing_request_Ball,
  input  logic              drawing_request_Tile,
  input  logic              drawing_request_Border,
  input  logic [1:0]        TileType,
  input  logic [3:0]        HitEdgeCode,
  input  logic [N_OBJ-1:0]  drawing_request_Obj,
  input  logic [GIFT_W-1:0] num_gifts_init,
  output logic              collision,
  output logic              SingleHitPulse,
  output logic              Remove_Gift,
  output logic [N_OBJ-1:0]  obj_hit,
  output logic [LIVES_W-1:0] lives,
  output logic [GIFT_W-1:0] gift_count,
  output logic              hole_visible,
  output logic              invulnerable,
  output logic [1:0]        game_state,
  output logic              victory,
  output logic              Loss,
  output logic              EndGame
);
  localparam int INV_W = INVULN_FRAMES > 0 ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [GIFT_W-1:0] gift_q, gift_d;
  logic [INV_W-1:0] inv_q, inv_d;
  logic col_f_q, col_f_d, gift_f_q, gift_f_d, hole_f_q, hole_f_d;
  logic hit_q, hit_d, rg_q, rg_d;
  logic [N_OBJ-1:0] obj_f_q, obj_f_d, obj_hit_q, obj_hit_d;
  logic play, col_ev, gift_ev, hole_ev, bot_ev, hole_vis, hole_first;
  logic [N_OBJ-1:0] obj_ev;
  assign play     = state_q == PLAY;
  assign hole_vis = gift_q == '0 && (state_q == PLAY || state_q == WIN);
  assign col_ev   = drawing_request_Ball & ((drawing_request_Tile & (TileType == 2'b01)) | drawing_request_Border);
  assign gift_ev  = drawing_request_Ball & drawing_request_Tile & (TileType == 2'b10);
  assign hole_ev  = drawing_request_Ball & drawing_request_Tile & (TileType == 2'b11) & hole_vis;
  assign bot_ev   = drawing_request_Ball & drawing_request_Border & (HitEdgeCode == 4'b0001);
  assign obj_ev   = {N_OBJ{drawing_request_Ball}} & drawing_request_Obj;
  assign collision      = col_ev & play;
  assign SingleHitPulse = hit_q;
  assign Remove_Gift    = rg_q;
  assign obj_hit        = obj_hit_q;
  assign lives          = lives_q;
  assign gift_count     = gift_q;
  assign hole_visible   = hole_vis;
  assign invulnerable   = |inv_q;
  assign game_state     = state_q;
  assign victory        = state_q == WIN;
  assign Loss           = state_q == LOSE;
  assign EndGame        = victory | Loss;
  // first-in-frame detection (a startOfFrame cycle already belongs to the new frame) and game rules
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    gift_d     = gift_q;
    inv_d      = inv_q;
    col_f_d    = (col_f_q & ~startOfFrame) | col_ev;
    gift_f_d   = (gift_f_q & ~startOfFrame) | gift_ev;
    hole_f_d   = (hole_f_q & ~startOfFrame) | hole_ev;
    obj_f_d    = (obj_f_q & {N_OBJ{~startOfFrame}}) | obj_ev;
    hit_d      = play & col_ev & ~(col_f_q & ~startOfFrame);
    rg_d       = play & gift_ev & ~(gift_f_q & ~startOfFrame);
    hole_first = play & hole_ev & ~(hole_f_q & ~startOfFrame);
    obj_hit_d  = {N_OBJ{play}} & obj_ev & ~(obj_f_q & {N_OBJ{~startOfFrame}});
    if (play) begin
      if (rg_d) gift_d = gift_q == '0 ? '0 : gift_q - 1'b1;
      if (hole_first) state_d = WIN;
      if (startOfFrame && inv_q != '0) inv_d = inv_q - 1'b1;
      if (|obj_hit_d && inv_q == '0) begin
        lives_d = lives_q == '0 ? '0 : lives_q - 1'b1;
        if (lives_q <= LIVES_W'(1)) state_d = LOSE;
        else inv_d = INV_LOAD;
      end
      if (bot_ev) state_d = LOSE;
    end else if (start_game) begin
      state_d  = PLAY;
      lives_d  = LIVES_W'(LIVES_INIT);
      gift_d   = num_gifts_init;
      inv_d    = '0;
      col_f_d  = 1'b0;
      gift_f_d = 1'b0;
      hole_f_d = 1'b0;
      obj_f_d  = '0;
    end
  end
  // state, counters, per-frame flags and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lives_q   <= '0;
      gift_q    <= '0;
      inv_q     <= '0;
      col_f_q   <= 1'b0;
      gift_f_q  <= 1'b0;
      hole_f_q  <= 1'b0;
      obj_f_q   <= '0;
      hit_q     <= 1'b0;
      rg_q      <= 1'b0;
      obj_hit_q <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      gift_q    <= gift_d;
      inv_q     <= inv_d;
      col_f_q   <= col_f_d;
      gift_f_q  <= gift_f_d;
      hole_f_q  <= hole_f_d;
      obj_f_q   <= obj_f_d;
      hit_q     <= hit_d;
      rg_q      <= rg_d;
      obj_hit_q <= obj_hit_d;
    end
  end
endmodule
